iic_slave: RTL
==============

Name: iic_slave

Overview:
- I2C responder (target) for the iic_master bus: 7-bit addressed, with an internal 8-bit-wide register file and an auto-incrementing register pointer.
- Decodes START, STOP, repeated START, address, register-address, write-data and read-data phases by oversampling SCL/SDA on clk_i.
- Drives SDA open-drain through an output-enable, and reports every register write to fabric as a one-cycle strobe.

Parameters:
- SLV_ADDR, 7'h4B, device address the block ACKs.
- REG_AW, 6, register-file address width; depth is 2**REG_AW; register-address byte bits above REG_AW-1 are ignored (aliasing).

Ports:
- clk_i  in  1  system clock; must be >= 8x SCL frequency.
- rst_i  in  1  reset; synchronous and active-high.
- scl_i  in  1  bus SCL (asynchronous).
- sda_i  in  1  bus SDA as read from the pad (asynchronous).
- sda_oe_o  out  1  1 = pull SDA low, 0 = release (pad is open-drain).
- wr_en_o  out  1  one-cycle strobe on each register write.
- wr_addr_o  out  REG_AW  register index written.
- wr_data_o  out  8  data written.
- busy_o  out  1  high while this device is addressed (from address ACK until STOP, NACK, or a non-matching START).

Behaviour:
- Input conditioning:
  - scl_i and sda_i each pass through a 2-FF synchronizer plus 1 history FF.
  - Edge and condition detection uses the last two synchronized samples: SCL rise, SCL fall, START = SDA fall while SCL high, STOP = SDA rise while SCL high.
- Reset (rst_i=1 at a clk_i edge):
  - sda_oe_o=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0, pointer=0, all registers=0, state=IDLE.
  - Mid-transfer reset releases SDA on the next edge.
- Bit timing:
  - SDA is sampled on the detected SCL rise, MSB first.
  - sda_oe_o changes only on the detected SCL fall; START/STOP processing is the only exception.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- Transitions:
  - Any START (including repeated START) from any state -> ADDR, bit count cleared, sda_oe_o=0.
  - Any STOP -> IDLE, sda_oe_o=0, busy_o=0.
  - ADDR: collect 8 bits; on the fall ending bit 8:
    - addr[7:1]==SLV_ADDR -> ADDR_ACK, sda_oe_o=1, busy_o=1.
    - else -> IDLE with no ACK; stay off the bus until the next START.
  - ADDR_ACK, on the fall ending the 9th clock:
    - R/W=0 -> REG, release SDA.
    - R/W=1 -> RDATA: load shift register from regs[pointer], pointer++, and drive MSB (sda_oe_o = ~bit).
  - REG: collect 8 bits; on the 8th fall, pointer <= byte[REG_AW-1:0], sda_oe_o=1 -> REG_ACK.
  - REG_ACK: on the fall, release -> WDATA.
  - WDATA: collect 8 bits; on the 8th fall:
    - wr_en_o pulses for exactly one clk_i, with wr_addr_o=pointer and wr_data_o=byte.
    - regs[pointer] <= byte, pointer++.
    - sda_oe_o=1 -> WDATA_ACK.
  - WDATA_ACK: on the fall, release -> WDATA (unbounded burst).
  - RDATA: shift out 8 bits, each placed after the SCL fall; on the 8th fall release SDA -> RDATA_ACK.
  - RDATA_ACK: sample the master's bit on the rise.
    - ACK (0): on the fall, load regs[pointer], pointer++, drive MSB -> RDATA.
    - NACK (1): on the fall, release -> IDLE, busy_o=0.
- Pointer arithmetic: modulo 2**REG_AW; it wraps from max to 0 and the carry is discarded.
- A START or STOP arriving inside a byte aborts that byte: no write strobe, no pointer change.
- wr_addr_o/wr_data_o hold their last values between strobes.

Test Plan:
- Write: START, 0x96 (0x4B+W), 0x36, 0xC2, STOP -> ACK on all 3 bytes; one wr_en_o pulse with wr_addr_o=0x36, wr_data_o=0xC2; busy_o falls at STOP.
- Combined read: write 0x36=0xC2 and 0x37=0x5A; then START, 0x96, 0x36, Sr, 0x97, read 2 bytes (ACK then NACK), STOP -> SDA carries 0xC2 then 0x5A; sda_oe_o=0 after NACK.
- Wrong address: START, 0x94, 0x36, 0xFF, STOP -> sda_oe_o stays 0 throughout; no wr_en_o; busy_o stays 0.
- Burst wrap: write burst at register 0x3F with data 0x11, 0x22 -> strobes at addr 0x3F then 0x00; a following read from 0x3F returns 0x11, 0x22.
- Abort/reset: STOP after 4 data bits -> no strobe, pointer unchanged. Assert rst_i while driving ACK -> sda_oe_o=0 on the next clk_i; subsequent read of 0x36 returns 0x00.
- Aliasing: register byte 0xF6 with REG_AW=6 -> write lands at index 0x36.

Source files
------------

// File: rtl/iic_slave.sv
// I2C target with an 8-bit register file, auto-incrementing pointer and write strobe.
module iic_slave #(
  parameter logic [6:0]  SLV_ADDR = 7'h4B,
  parameter int unsigned REG_AW   = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe_o,
  output logic              wr_en_o,
  output logic [REG_AW-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic              busy_o
);

  localparam int unsigned DEPTH = 2 ** REG_AW;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t            state, state_d;
  logic              scl_m, scl_s, scl_h;
  logic              sda_m, sda_s, sda_h;
  logic [3:0]        cnt;
  logic [7:0]        shift;
  logic [REG_AW-1:0] ptr;
  logic              rw;
  logic              ack_bit;
  logic [7:0]        regs [DEPTH];

  logic              oe_d, busy_d;
  logic              cnt_clr, wr_fire, rd_load, tx_shift, ptr_set, addr_done;

  // Bus conditions from the last two synchronized samples
  logic scl_rise, scl_fall, start_c, stop_c, collecting;
  assign scl_rise   = scl_s & ~scl_h;
  assign scl_fall   = ~scl_s & scl_h;
  assign start_c    = scl_s & scl_h & sda_h & ~sda_s;
  assign stop_c     = scl_s & scl_h & ~sda_h & sda_s;
  assign collecting = (state == ADDR) || (state == REG) || (state == WDATA);

  // Two-FF synchronizers plus one history stage; reset to the idle-bus level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      {scl_m, scl_s, scl_h} <= 3'b111;
      {sda_m, sda_s, sda_h} <= 3'b111;
    end else begin
      {scl_m, scl_s, scl_h} <= {scl_i, scl_m, scl_s};
      {sda_m, sda_s, sda_h} <= {sda_i, sda_m, sda_s};
    end
  end

  // Next-state and SDA/busy decisions; START/STOP override edge handling
  always_comb begin
    state_d   = state;
    oe_d      = sda_oe_o;
    busy_d    = busy_o;
    cnt_clr   = 1'b0;
    wr_fire   = 1'b0;
    rd_load   = 1'b0;
    tx_shift  = 1'b0;
    ptr_set   = 1'b0;
    addr_done = 1'b0;
    if (start_c) begin
      state_d = ADDR;
      oe_d    = 1'b0;
      cnt_clr = 1'b1;
    end else if (stop_c) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      cnt_clr = 1'b1;
    end else if (scl_fall) begin
      unique case (state)
        ADDR: if (cnt == 4'd8) begin
          cnt_clr   = 1'b1;
          addr_done = 1'b1;
          if (shift[7:1] == SLV_ADDR) begin
            state_d = ADDR_ACK;
            oe_d    = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
          end
        end
        ADDR_ACK: begin
          cnt_clr = 1'b1;
          if (rw) begin
            state_d = RDATA;
            rd_load = 1'b1;
            oe_d    = ~regs[ptr][7];
          end else begin
            state_d = REG;
            oe_d    = 1'b0;
          end
        end
        REG: if (cnt == 4'd8) begin
          state_d = REG_ACK;
          oe_d    = 1'b1;
          cnt_clr = 1'b1;
          ptr_set = 1'b1;
        end
        REG_ACK, WDATA_ACK: begin
          state_d = WDATA;
          oe_d    = 1'b0;
          cnt_clr = 1'b1;
        end
        WDATA: if (cnt == 4'd8) begin
          state_d = WDATA_ACK;
          oe_d    = 1'b1;
          cnt_clr = 1'b1;
          wr_fire = 1'b1;
        end
        RDATA: begin
          if (cnt == 4'd8) begin
            state_d = RDATA_ACK;
            oe_d    = 1'b0;
            cnt_clr = 1'b1;
          end else begin
            tx_shift = 1'b1;
            oe_d     = ~shift[6];
          end
        end
        RDATA_ACK: begin
          cnt_clr = 1'b1;
          if (!ack_bit) begin
            state_d = RDATA;
            rd_load = 1'b1;
            oe_d    = ~regs[ptr][7];
          end else begin
            state_d = IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // State register and datapath
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      sda_oe_o  <= 1'b0;
      busy_o    <= 1'b0;
      wr_en_o   <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
      cnt       <= '0;
      shift     <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      ack_bit   <= 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      state    <= state_d;
      sda_oe_o <= oe_d;
      busy_o   <= busy_d;
      wr_en_o  <= wr_fire;

      if (cnt_clr)
        cnt <= '0;
      else if (scl_rise && (collecting || state == RDATA) && cnt < 4'd8)
        cnt <= cnt + 4'd1;

      if (rd_load)
        shift <= regs[ptr];
      else if (tx_shift)
        shift <= {shift[6:0], 1'b0};
      else if (scl_rise && collecting)
        shift <= {shift[6:0], sda_s};

      if (addr_done) rw <= shift[0];
      if (scl_rise && state == RDATA_ACK) ack_bit <= sda_s;

      if (ptr_set)
        ptr <= shift[REG_AW-1:0];
      else if (rd_load || wr_fire)
        ptr <= ptr + REG_AW'(1);

      if (wr_fire) begin
        regs[ptr] <= shift;
        wr_addr_o <= ptr;
        wr_data_o <= shift;
      end
    end
  end

endmodule
